// File: rtl/wb_arbiter_pkg.sv
// Shared register-file definitions and writeback types for the load/ALU
// writeback arbiter.
package wb_arbiter_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum     = 32;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic RstEnable    = 1'b1;

  typedef logic [RegBus-1:0]     reg_data_t;
  typedef logic [RegAddrBus-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } ld_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LOAD
  } wb_src_e;

  function automatic logic [RegNum-1:0] reg_onehot(input reg_addr_t addr);
    return RegNum'(1) << addr;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering returned loads until they win the
// register-file write port.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PtrW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; count alone decides
  // which entries are valid, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Depth is a power of two, so pointers wrap by natural overflow.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU results have priority, buffered load
// returns are forced through after STARVE_LIMIT lost cycles.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_we,
  input  logic [RegAddrBus-1:0] alu_waddr,
  input  logic [RegBus-1:0]     alu_wdata,
  output logic                  alu_stall,
  input  logic                  ld_issue,
  input  logic [RegAddrBus-1:0] ld_issue_addr,
  input  logic                  ld_valid,
  input  logic [RegAddrBus-1:0] ld_waddr,
  input  logic [RegBus-1:0]     ld_wdata,
  output logic                  ld_ready,
  output logic                  we,
  output logic [RegAddrBus-1:0] waddr,
  output logic [RegBus-1:0]     wdata,
  output logic [RegNum-1:0]     busy_mask
);

  localparam int StarveW = $clog2(STARVE_LIMIT + 1);
  localparam int CntW    = $clog2(FIFO_DEPTH) + 1;

  logic               alu_req;
  logic               ld_push;
  logic               ld_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_nonempty;
  logic [CntW-1:0]    fifo_count;
  ld_entry_t          push_entry;
  ld_entry_t          head;
  logic [StarveW-1:0] starve;
  logic [StarveW-1:0] starve_next;
  logic               starve_hit;
  wb_src_e            src;
  logic [RegNum-1:0]  busy_next;

  assign alu_req       = alu_we & (alu_waddr != '0);
  assign ld_ready      = (rst != RstEnable) & ~fifo_full;
  // Returns to r0 complete the handshake but never enter the buffer.
  assign ld_push       = ld_valid & ld_ready & (ld_waddr != '0);
  assign push_entry    = '{addr: ld_waddr, data: ld_wdata};
  assign fifo_nonempty = (fifo_count != '0);
  assign starve_hit    = fifo_nonempty & (starve == StarveW'(STARVE_LIMIT));

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ld_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ld_push),
    .wdata (push_entry),
    .pop   (ld_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    src         = SRC_NONE;
    starve_next = '0;
    if (alu_req && !starve_hit) begin
      src = SRC_ALU;
    end else if (fifo_nonempty) begin
      src = SRC_LOAD;
    end
    if (src == SRC_ALU && fifo_nonempty) begin
      starve_next = starve_hit ? starve : starve + 1'b1;
    end
  end

  assign ld_pop    = (src == SRC_LOAD) & ~fifo_empty;
  assign alu_stall = alu_req & (src == SRC_LOAD);

  // A new issue to the register being retired wins, keeping the bit set.
  always_comb begin
    busy_next = busy_mask;
    if (ld_pop) busy_next = busy_next & ~reg_onehot(head.addr);
    if (ld_issue && ld_issue_addr != '0) busy_next = busy_next | reg_onehot(ld_issue_addr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      we        <= WriteDisable;
      waddr     <= '0;
      wdata     <= '0;
      starve    <= '0;
      busy_mask <= '0;
    end else begin
      starve    <= starve_next;
      busy_mask <= busy_next;
      unique case (src)
        SRC_ALU: begin
          we    <= WriteEnable;
          waddr <= alu_waddr;
          wdata <= alu_wdata;
        end
        SRC_LOAD: begin
          we    <= WriteEnable;
          waddr <= head.addr;
          wdata <= head.data;
        end
        default: begin
          we    <= WriteDisable;
          waddr <= '0;
          wdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: ALU vector table, load path, starvation,
// zero-register and reset sequences, with a write scoreboard.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_we = 1'b0;
  logic [4:0]  alu_waddr = '0;
  logic [31:0] alu_wdata = '0;
  logic        alu_stall;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_issue_addr = '0;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_waddr = '0;
  logic [31:0] ld_wdata = '0;
  logic        ld_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] busy_mask;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic        a_we;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        exp_stall;
    logic        exp_we;
  } vec_t;
  vec_t vecs[6];

  wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata), .alu_stall(alu_stall),
    .ld_issue(ld_issue), .ld_issue_addr(ld_issue_addr),
    .ld_valid(ld_valid), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata), .ld_ready(ld_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sb(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got waddr %h wdata %h, expected none", waddr, wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("sb_waddr", 32'(waddr), 32'(e.addr));
        check("sb_wdata", wdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_ready[7];
    logic exp_stall[7];
    int   ld_n;
    int   alu_n;
    int   pop_n;

    vecs[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 5'd9,  32'h0000_AAAA, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 5'd31, 32'hCAFE_F00D, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 5'd1,  32'h0000_0000, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b1};
    // exp_we of entry i is the write caused by entry i-1's request.
    for (int i = 0; i < 6; i++) begin
      if (i == 0) vecs[i].exp_we = 1'b0;
      else vecs[i].exp_we = vecs[i-1].a_we & (vecs[i-1].a_addr != 5'd0);
    end

    // Reset state, with an ALU request present that must not stall.
    alu_we = 1'b1;
    alu_waddr = 5'd6;
    #2;
    check("rst_we", 32'(we), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_busy", busy_mask, 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_alu_stall", 32'(alu_stall), 32'd0);
    alu_we = 1'b0;
    next_cycle();
    rst = 1'b0;
    #1;
    check("rel_ld_ready", 32'(ld_ready), 32'd1);
    next_cycle();

    // ALU-only vectors: stall never asserted with empty buffer, latency 1.
    for (int i = 0; i < 6; i++) begin
      alu_we = vecs[i].a_we;
      alu_waddr = vecs[i].a_addr;
      alu_wdata = vecs[i].a_data;
      check("tbl_we", 32'(we), 32'(vecs[i].exp_we));
      #2;
      check("tbl_stall", 32'(alu_stall), 32'(vecs[i].exp_stall));
      if (vecs[i].a_we && vecs[i].a_addr != 5'd0) push_sb(vecs[i].a_addr, vecs[i].a_data);
      next_cycle();
    end
    alu_we = 1'b0;
    next_cycle();
    check("idle_we", 32'(we), 32'd0);

    // Load path: issue r7, return later, written two edges after accept.
    ld_issue = 1'b1;
    ld_issue_addr = 5'd7;
    next_cycle();
    ld_issue = 1'b0;
    check("ld_busy_set", busy_mask, 32'h0000_0080);
    next_cycle();
    ld_valid = 1'b1;
    ld_waddr = 5'd7;
    ld_wdata = 32'hDEAD_BEEF;
    #1;
    check("ld_ready_hi", 32'(ld_ready), 32'd1);
    push_sb(5'd7, 32'hDEAD_BEEF);
    next_cycle();
    ld_valid = 1'b0;
    check("ld_we_n1", 32'(we), 32'd0);
    check("ld_busy_n1", busy_mask, 32'h0000_0080);
    next_cycle();
    check("ld_we_n2", 32'(we), 32'd1);
    check("ld_waddr_n2", 32'(waddr), 32'd7);
    check("ld_busy_clr", busy_mask, 32'd0);
    next_cycle();
    check("ld_we_n3", 32'(we), 32'd0);

    // Pop of r3 on the same edge as a new issue to r3.
    ld_issue = 1'b1;
    ld_issue_addr = 5'd3;
    next_cycle();
    ld_issue = 1'b0;
    ld_valid = 1'b1;
    ld_waddr = 5'd3;
    ld_wdata = 32'h0000_0033;
    push_sb(5'd3, 32'h0000_0033);
    next_cycle();
    ld_valid = 1'b0;
    ld_issue = 1'b1;
    ld_issue_addr = 5'd3;
    next_cycle();
    ld_issue = 1'b0;
    check("same_edge_we", 32'(we), 32'd1);
    check("same_edge_busy", busy_mask, 32'h0000_0008);
    next_cycle();
    check("same_edge_busy2", busy_mask, 32'h0000_0008);
    ld_valid = 1'b1;
    ld_waddr = 5'd3;
    ld_wdata = 32'h0000_0034;
    push_sb(5'd3, 32'h0000_0034);
    next_cycle();
    ld_valid = 1'b0;
    next_cycle();
    check("r3_busy_clr", busy_mask, 32'd0);

    // Zero register on both paths: no write, no push, no pending bit.
    alu_we = 1'b1;
    alu_waddr = 5'd0;
    alu_wdata = 32'h1111_1111;
    ld_valid = 1'b1;
    ld_waddr = 5'd0;
    ld_wdata = 32'h2222_2222;
    ld_issue = 1'b1;
    ld_issue_addr = 5'd0;
    #1;
    check("zero_stall", 32'(alu_stall), 32'd0);
    check("zero_ld_ready", 32'(ld_ready), 32'd1);
    next_cycle();
    alu_we = 1'b0;
    ld_valid = 1'b0;
    ld_issue = 1'b0;
    check("zero_we1", 32'(we), 32'd0);
    next_cycle();
    check("zero_we2", 32'(we), 32'd0);
    check("zero_busy", busy_mask, 32'd0);
    next_cycle();

    // Starvation: ALU every cycle, three loads offered back to back.
    exp_ready = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_stall = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ld_n = 0;
    alu_n = 0;
    pop_n = 0;
    for (int c = 0; c < 7; c++) begin
      alu_we = 1'b1;
      alu_waddr = 5'(10 + alu_n);
      alu_wdata = 32'hA000_0000 + 32'(alu_n);
      ld_valid = (ld_n < 3);
      ld_waddr = 5'(20 + ld_n);
      ld_wdata = 32'h1000_0000 + 32'(20 + ld_n);
      #2;
      check("stv_ready", 32'(ld_ready), 32'(exp_ready[c]));
      check("stv_stall", 32'(alu_stall), 32'(exp_stall[c]));
      if (exp_stall[c]) begin
        push_sb(5'(20 + pop_n), 32'h1000_0000 + 32'(20 + pop_n));
        pop_n++;
      end else begin
        push_sb(5'(10 + alu_n), 32'hA000_0000 + 32'(alu_n));
        alu_n++;
      end
      if (exp_ready[c] && ld_valid) ld_n++;
      next_cycle();
    end
    alu_we = 1'b0;
    ld_valid = 1'b0;
    #1;
    check("drain_ready_full", 32'(ld_ready), 32'd0);
    check("drain_stall", 32'(alu_stall), 32'd0);
    push_sb(5'd21, 32'h1000_0015);
    next_cycle();
    check("drain_ready", 32'(ld_ready), 32'd1);
    push_sb(5'd22, 32'h1000_0016);
    next_cycle();
    check("drain_we", 32'(we), 32'd1);
    next_cycle();
    check("drain_idle", 32'(we), 32'd0);

    // Reset with two buffered loads.
    alu_we = 1'b1;
    alu_waddr = 5'd4;
    alu_wdata = 32'h0000_0044;
    ld_valid = 1'b1;
    ld_waddr = 5'd12;
    ld_wdata = 32'h0000_0C0C;
    ld_issue = 1'b1;
    ld_issue_addr = 5'd12;
    push_sb(5'd4, 32'h0000_0044);
    next_cycle();
    alu_wdata = 32'h0000_0045;
    ld_waddr = 5'd13;
    ld_wdata = 32'h0000_0D0D;
    ld_issue = 1'b0;
    next_cycle();
    ld_valid = 1'b0;
    check("pre_rst_full", 32'(ld_ready), 32'd0);
    check("pre_rst_we", 32'(we), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_we", 32'(we), 32'd0);
    check("mid_rst_waddr", 32'(waddr), 32'd0);
    check("mid_rst_wdata", wdata, 32'd0);
    check("mid_rst_busy", busy_mask, 32'd0);
    check("mid_rst_ready", 32'(ld_ready), 32'd0);
    check("mid_rst_stall", 32'(alu_stall), 32'd0);
    alu_we = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(ld_ready), 32'd1);
    check("post_rst_busy", busy_mask, 32'd0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      check("post_rst_we", 32'(we), 32'd0);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
